// File: rtl/mcash_rtn_rob.sv
// Return-path reorder buffer: three independent in-order channel drains fed by tagged out-of-order returns.
// Optional macro MCASH_RTN_BYPASS_EN adds a 0-cycle path for beats that land on a channel's head slot.
module mcash_rtn_rob #(
  parameter int ROB_DEPTH = 4,
  parameter int ROB_AW    = 2,
  parameter int DATA_W    = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ch0_alloc_valid_i,
  output logic              ch0_alloc_ready_o,
  output logic [ROB_AW-1:0] ch0_alloc_rob_num_o,
  input  logic              ch1_alloc_valid_i,
  output logic              ch1_alloc_ready_o,
  output logic [ROB_AW-1:0] ch1_alloc_rob_num_o,
  input  logic              ch2_alloc_valid_i,
  output logic              ch2_alloc_ready_o,
  output logic [ROB_AW-1:0] ch2_alloc_rob_num_o,
  input  logic              sc_xbar_valid_i,
  output logic              sc_xbar_ready_o,
  input  logic [1:0]        sc_xbar_ch_id_i,
  input  logic [ROB_AW-1:0] sc_xbar_rob_num_i,
  input  logic [DATA_W-1:0] sc_xbar_data_i,
  output logic              mcash_ch0_rtn_valid_o,
  input  logic              mcash_ch0_rtn_ready_i,
  output logic [DATA_W-1:0] mcash_ch0_rtn_data_o,
  output logic              mcash_ch1_rtn_valid_o,
  input  logic              mcash_ch1_rtn_ready_i,
  output logic [DATA_W-1:0] mcash_ch1_rtn_data_o,
  output logic              mcash_ch2_rtn_valid_o,
  input  logic              mcash_ch2_rtn_ready_i,
  output logic [DATA_W-1:0] mcash_ch2_rtn_data_o,
  output logic              rob_err_o
);

  localparam int NCH = 3;

  logic [NCH-1:0]    alloc_valid;
  logic [NCH-1:0]    alloc_ready;
  logic [NCH-1:0]    rtn_valid;
  logic [NCH-1:0]    rtn_ready;
  logic [NCH-1:0]    bad_hit;
  logic [ROB_AW-1:0] alloc_rob_num [NCH];
  logic [DATA_W-1:0] rtn_data [NCH];
  logic              err_q;

  assign alloc_valid = {ch2_alloc_valid_i, ch1_alloc_valid_i, ch0_alloc_valid_i};
  assign rtn_ready   = {mcash_ch2_rtn_ready_i, mcash_ch1_rtn_ready_i, mcash_ch0_rtn_ready_i};

  assign ch0_alloc_ready_o     = alloc_ready[0];
  assign ch1_alloc_ready_o     = alloc_ready[1];
  assign ch2_alloc_ready_o     = alloc_ready[2];
  assign ch0_alloc_rob_num_o   = alloc_rob_num[0];
  assign ch1_alloc_rob_num_o   = alloc_rob_num[1];
  assign ch2_alloc_rob_num_o   = alloc_rob_num[2];
  assign mcash_ch0_rtn_valid_o = rtn_valid[0];
  assign mcash_ch1_rtn_valid_o = rtn_valid[1];
  assign mcash_ch2_rtn_valid_o = rtn_valid[2];
  assign mcash_ch0_rtn_data_o  = rtn_data[0];
  assign mcash_ch1_rtn_data_o  = rtn_data[1];
  assign mcash_ch2_rtn_data_o  = rtn_data[2];
  assign sc_xbar_ready_o       = 1'b1;
  assign rob_err_o             = err_q;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    logic [ROB_DEPTH-1:0] alloc_q;
    logic [ROB_DEPTH-1:0] done_q;
    logic [DATA_W-1:0]    data_q [ROB_DEPTH];
    logic [ROB_AW-1:0]    head_q;
    logic [ROB_AW-1:0]    tail_q;
    logic [ROB_AW:0]      count_q;
    logic                 hit;
    logic                 slot_ok;
    logic                 wr_en;
    logic                 store_en;
    logic                 do_alloc;
    logic                 do_drain;

    assign hit              = sc_xbar_valid_i && (sc_xbar_ch_id_i == 2'(n));
    assign slot_ok          = alloc_q[sc_xbar_rob_num_i] && !done_q[sc_xbar_rob_num_i];
    assign wr_en            = hit && slot_ok;
    assign bad_hit[n]       = hit && !slot_ok;
    assign alloc_ready[n]   = (count_q < (ROB_AW+1)'(ROB_DEPTH));
    assign alloc_rob_num[n] = tail_q;
    assign do_alloc         = alloc_valid[n] && alloc_ready[n];
    assign do_drain         = rtn_valid[n] && rtn_ready[n];

`ifdef MCASH_RTN_BYPASS_EN
    // A legal beat on the head slot is forwarded at once; if consumed it never touches storage.
    logic byp;
    assign byp          = wr_en && (sc_xbar_rob_num_i == head_q);
    assign rtn_valid[n] = done_q[head_q] || byp;
    assign rtn_data[n]  = done_q[head_q] ? data_q[head_q] : sc_xbar_data_i;
    assign store_en     = wr_en && !(byp && rtn_ready[n]);
`else
    assign rtn_valid[n] = done_q[head_q];
    assign rtn_data[n]  = data_q[head_q];
    assign store_en     = wr_en;
`endif

    // Drain clears before allocate sets, so a reused slot index ends up allocated and pending.
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        alloc_q <= '0;
        done_q  <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
          if (do_drain && (head_q == ROB_AW'(i))) begin
            alloc_q[i] <= 1'b0;
            done_q[i]  <= 1'b0;
          end else if (store_en && (sc_xbar_rob_num_i == ROB_AW'(i))) begin
            done_q[i] <= 1'b1;
          end
          if (do_alloc && (tail_q == ROB_AW'(i))) begin
            alloc_q[i] <= 1'b1;
            done_q[i]  <= 1'b0;
          end
        end
        if (do_alloc) tail_q <= tail_q + 1'b1;
        if (do_drain) head_q <= head_q + 1'b1;
        case ({do_alloc, do_drain})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end

    always_ff @(posedge clk_i) begin
      if (store_en) data_q[sc_xbar_rob_num_i] <= sc_xbar_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else if (sc_xbar_valid_i && ((sc_xbar_ch_id_i == 2'd3) || (|bad_hit))) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mcash_rtn_rob.sv
// Directed self-checking bench for mcash_rtn_rob in its default (non-bypass) build.
module tb_mcash_rtn_rob;

  localparam int DW = 128;
  localparam int AW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          ch0_alloc_valid_i, ch1_alloc_valid_i, ch2_alloc_valid_i;
  logic          ch0_alloc_ready_o, ch1_alloc_ready_o, ch2_alloc_ready_o;
  logic [AW-1:0] ch0_alloc_rob_num_o, ch1_alloc_rob_num_o, ch2_alloc_rob_num_o;
  logic          sc_xbar_valid_i, sc_xbar_ready_o;
  logic [1:0]    sc_xbar_ch_id_i;
  logic [AW-1:0] sc_xbar_rob_num_i;
  logic [DW-1:0] sc_xbar_data_i;
  logic          mcash_ch0_rtn_valid_o, mcash_ch1_rtn_valid_o, mcash_ch2_rtn_valid_o;
  logic          mcash_ch0_rtn_ready_i, mcash_ch1_rtn_ready_i, mcash_ch2_rtn_ready_i;
  logic [DW-1:0] mcash_ch0_rtn_data_o, mcash_ch1_rtn_data_o, mcash_ch2_rtn_data_o;
  logic          rob_err_o;

  int vectors = 0;
  int miscompares = 0;

  mcash_rtn_rob #(.ROB_DEPTH(4), .ROB_AW(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ch0_alloc_valid_i(ch0_alloc_valid_i), .ch0_alloc_ready_o(ch0_alloc_ready_o), .ch0_alloc_rob_num_o(ch0_alloc_rob_num_o),
    .ch1_alloc_valid_i(ch1_alloc_valid_i), .ch1_alloc_ready_o(ch1_alloc_ready_o), .ch1_alloc_rob_num_o(ch1_alloc_rob_num_o),
    .ch2_alloc_valid_i(ch2_alloc_valid_i), .ch2_alloc_ready_o(ch2_alloc_ready_o), .ch2_alloc_rob_num_o(ch2_alloc_rob_num_o),
    .sc_xbar_valid_i(sc_xbar_valid_i), .sc_xbar_ready_o(sc_xbar_ready_o), .sc_xbar_ch_id_i(sc_xbar_ch_id_i),
    .sc_xbar_rob_num_i(sc_xbar_rob_num_i), .sc_xbar_data_i(sc_xbar_data_i),
    .mcash_ch0_rtn_valid_o(mcash_ch0_rtn_valid_o), .mcash_ch0_rtn_ready_i(mcash_ch0_rtn_ready_i), .mcash_ch0_rtn_data_o(mcash_ch0_rtn_data_o),
    .mcash_ch1_rtn_valid_o(mcash_ch1_rtn_valid_o), .mcash_ch1_rtn_ready_i(mcash_ch1_rtn_ready_i), .mcash_ch1_rtn_data_o(mcash_ch1_rtn_data_o),
    .mcash_ch2_rtn_valid_o(mcash_ch2_rtn_valid_o), .mcash_ch2_rtn_ready_i(mcash_ch2_rtn_ready_i), .mcash_ch2_rtn_data_o(mcash_ch2_rtn_data_o),
    .rob_err_o(rob_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    ch0_alloc_valid_i = 1'b0; ch1_alloc_valid_i = 1'b0; ch2_alloc_valid_i = 1'b0;
    sc_xbar_valid_i = 1'b0; sc_xbar_ch_id_i = 2'd0; sc_xbar_rob_num_i = '0; sc_xbar_data_i = '0;
    mcash_ch0_rtn_ready_i = 1'b0; mcash_ch1_rtn_ready_i = 1'b0; mcash_ch2_rtn_ready_i = 1'b0;
  endtask

  task automatic send_beat(input logic [1:0] ch, input int rob, input logic [DW-1:0] data);
    sc_xbar_valid_i = 1'b1; sc_xbar_ch_id_i = ch; sc_xbar_rob_num_i = AW'(rob); sc_xbar_data_i = data;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst_i = 1'b0;
    step(); step();
    rst_i = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b0;
    #1;
    vectors++; if ({ch2_alloc_ready_o, ch1_alloc_ready_o, ch0_alloc_ready_o} !== 3'b111) begin
      miscompares++; $display("[TB] FAIL reset_alloc_ready: got %b expected 111", {ch2_alloc_ready_o, ch1_alloc_ready_o, ch0_alloc_ready_o}); end
    vectors++; if ({ch2_alloc_rob_num_o, ch1_alloc_rob_num_o, ch0_alloc_rob_num_o} !== 6'd0) begin
      miscompares++; $display("[TB] FAIL reset_rob_num: got %h expected 0", {ch2_alloc_rob_num_o, ch1_alloc_rob_num_o, ch0_alloc_rob_num_o}); end
    vectors++; if ({mcash_ch2_rtn_valid_o, mcash_ch1_rtn_valid_o, mcash_ch0_rtn_valid_o} !== 3'b000) begin
      miscompares++; $display("[TB] FAIL reset_rtn_valid: got %b expected 000", {mcash_ch2_rtn_valid_o, mcash_ch1_rtn_valid_o, mcash_ch0_rtn_valid_o}); end
    vectors++; if (rob_err_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_err: got %b expected 0", rob_err_o); end
    vectors++; if (sc_xbar_ready_o !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_sc_ready: got %b expected 1", sc_xbar_ready_o); end
    step(); step();
    rst_i = 1'b1;
    #1;
  endtask

  task automatic test_single_return();
    ch0_alloc_valid_i = 1'b1;
    #1;
    vectors++; if (ch0_alloc_rob_num_o !== 2'd0) begin
      miscompares++; $display("[TB] FAIL single_rob_num: got %0d expected 0", ch0_alloc_rob_num_o); end
    step();
    ch0_alloc_valid_i = 1'b0;
    send_beat(2'd0, 0, DW'(128'hA5));
    #1;
    vectors++; if (mcash_ch0_rtn_valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL single_early_valid: got %b expected 0", mcash_ch0_rtn_valid_o); end
    step();
    sc_xbar_valid_i = 1'b0;
    vectors++; if (mcash_ch0_rtn_valid_o !== 1'b1) begin
      miscompares++; $display("[TB] FAIL single_valid: got %b expected 1", mcash_ch0_rtn_valid_o); end
    vectors++; if (mcash_ch0_rtn_data_o !== DW'(128'hA5)) begin
      miscompares++; $display("[TB] FAIL single_data: got %h expected a5", mcash_ch0_rtn_data_o); end
    vectors++; if ({mcash_ch2_rtn_valid_o, mcash_ch1_rtn_valid_o} !== 2'b00) begin
      miscompares++; $display("[TB] FAIL single_other_ch: got %b expected 00", {mcash_ch2_rtn_valid_o, mcash_ch1_rtn_valid_o}); end
    mcash_ch0_rtn_ready_i = 1'b1;
    step();
    mcash_ch0_rtn_ready_i = 1'b0;
    vectors++; if (mcash_ch0_rtn_valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL single_drained: got %b expected 0", mcash_ch0_rtn_valid_o); end
  endtask

  task automatic test_out_of_order();
    int order [4] = '{3, 1, 2, 0};
    for (int i = 0; i < 4; i++) begin
      ch1_alloc_valid_i = 1'b1;
      #1;
      vectors++; if (ch1_alloc_rob_num_o !== AW'(i)) begin
        miscompares++; $display("[TB] FAIL ooo_rob_num: got %0d expected %0d", ch1_alloc_rob_num_o, i); end
      step();
    end
    ch1_alloc_valid_i = 1'b0;
    mcash_ch1_rtn_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_beat(2'd1, order[k], DW'(256 + order[k]));
      #1;
      vectors++; if (mcash_ch1_rtn_valid_o !== 1'b0) begin
        miscompares++; $display("[TB] FAIL ooo_wait_head: got %b expected 0 at beat %0d", mcash_ch1_rtn_valid_o, k); end
      step();
    end
    sc_xbar_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (mcash_ch1_rtn_valid_o !== 1'b1 || mcash_ch1_rtn_data_o !== DW'(256 + k)) begin
        miscompares++; $display("[TB] FAIL ooo_order: got valid=%b data=%h expected valid=1 data=%h", mcash_ch1_rtn_valid_o, mcash_ch1_rtn_data_o, DW'(256 + k)); end
      step();
    end
    vectors++; if (mcash_ch1_rtn_valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL ooo_empty: got %b expected 0", mcash_ch1_rtn_valid_o); end
    mcash_ch1_rtn_ready_i = 1'b0;
  endtask

  task automatic test_full_backpressure();
    for (int i = 0; i < 4; i++) begin
      ch2_alloc_valid_i = 1'b1;
      #1;
      vectors++; if (ch2_alloc_ready_o !== 1'b1 || ch2_alloc_rob_num_o !== AW'(i)) begin
        miscompares++; $display("[TB] FAIL full_alloc: got ready=%b rob=%0d expected ready=1 rob=%0d", ch2_alloc_ready_o, ch2_alloc_rob_num_o, i); end
      step();
    end
    ch2_alloc_valid_i = 1'b0;
    vectors++; if (ch2_alloc_ready_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL full_ready_low: got %b expected 0", ch2_alloc_ready_o); end
    for (int i = 0; i < 4; i++) begin
      send_beat(2'd2, i, DW'(512 + i));
      step();
    end
    sc_xbar_valid_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vectors++; if (mcash_ch2_rtn_valid_o !== 1'b1 || mcash_ch2_rtn_data_o !== DW'(512) || ch2_alloc_ready_o !== 1'b0) begin
        miscompares++; $display("[TB] FAIL full_hold: got valid=%b data=%h ready=%b expected 1/200/0", mcash_ch2_rtn_valid_o, mcash_ch2_rtn_data_o, ch2_alloc_ready_o); end
      step();
    end
    mcash_ch2_rtn_ready_i = 1'b1;
    #1;
    vectors++; if (ch2_alloc_ready_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL full_no_passthru: got %b expected 0", ch2_alloc_ready_o); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (mcash_ch2_rtn_valid_o !== 1'b1 || mcash_ch2_rtn_data_o !== DW'(512 + k)) begin
        miscompares++; $display("[TB] FAIL full_drain: got valid=%b data=%h expected valid=1 data=%h", mcash_ch2_rtn_valid_o, mcash_ch2_rtn_data_o, DW'(512 + k)); end
      step();
      if (k == 0) begin
        vectors++; if (ch2_alloc_ready_o !== 1'b1) begin
          miscompares++; $display("[TB] FAIL full_ready_restore: got %b expected 1", ch2_alloc_ready_o); end
      end
    end
    vectors++; if (mcash_ch2_rtn_valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL full_empty: got %b expected 0", mcash_ch2_rtn_valid_o); end
    mcash_ch2_rtn_ready_i = 1'b0;
  endtask

  task automatic test_errors();
    pulse_reset();
    send_beat(2'd2, 1, DW'(128'hDEAD));
    step();
    sc_xbar_valid_i = 1'b0;
    vectors++; if (rob_err_o !== 1'b1 || mcash_ch2_rtn_valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL err_unalloc: got err=%b valid=%b expected 1/0", rob_err_o, mcash_ch2_rtn_valid_o); end
    pulse_reset();
    vectors++; if (rob_err_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL err_cleared: got %b expected 0", rob_err_o); end
    ch0_alloc_valid_i = 1'b1;
    step();
    ch0_alloc_valid_i = 1'b0;
    send_beat(2'd3, 0, DW'(128'hEE));
    step();
    sc_xbar_valid_i = 1'b0;
    vectors++; if (rob_err_o !== 1'b1 || mcash_ch0_rtn_valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL err_chid3: got err=%b valid=%b expected 1/0", rob_err_o, mcash_ch0_rtn_valid_o); end
    send_beat(2'd0, 0, DW'(128'h77));
    step();
    sc_xbar_valid_i = 1'b0;
    vectors++; if (mcash_ch0_rtn_valid_o !== 1'b1 || mcash_ch0_rtn_data_o !== DW'(128'h77)) begin
      miscompares++; $display("[TB] FAIL err_chid3_recover: got valid=%b data=%h expected 1/77", mcash_ch0_rtn_valid_o, mcash_ch0_rtn_data_o); end
    pulse_reset();
    ch1_alloc_valid_i = 1'b1;
    step(); step();
    ch1_alloc_valid_i = 1'b0;
    send_beat(2'd1, 1, DW'(128'h11));
    step();
    vectors++; if (rob_err_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL err_legal_beat: got %b expected 0", rob_err_o); end
    send_beat(2'd1, 1, DW'(128'h22));
    step();
    vectors++; if (rob_err_o !== 1'b1) begin
      miscompares++; $display("[TB] FAIL err_duplicate: got %b expected 1", rob_err_o); end
    send_beat(2'd1, 0, DW'(128'h10));
    step();
    sc_xbar_valid_i = 1'b0;
    vectors++; if (mcash_ch1_rtn_valid_o !== 1'b1 || mcash_ch1_rtn_data_o !== DW'(128'h10)) begin
      miscompares++; $display("[TB] FAIL err_dup_slot0: got valid=%b data=%h expected 1/10", mcash_ch1_rtn_valid_o, mcash_ch1_rtn_data_o); end
    mcash_ch1_rtn_ready_i = 1'b1;
    step();
    vectors++; if (mcash_ch1_rtn_valid_o !== 1'b1 || mcash_ch1_rtn_data_o !== DW'(128'h11)) begin
      miscompares++; $display("[TB] FAIL err_dup_kept: got valid=%b data=%h expected 1/11", mcash_ch1_rtn_valid_o, mcash_ch1_rtn_data_o); end
    step();
    vectors++; if (mcash_ch1_rtn_valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL err_dup_empty: got %b expected 0", mcash_ch1_rtn_valid_o); end
    mcash_ch1_rtn_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    pulse_reset();
    ch1_alloc_valid_i = 1'b1;
    step(); step();
    ch1_alloc_valid_i = 1'b0;
    send_beat(2'd1, 0, DW'(128'h33));
    step();
    sc_xbar_valid_i = 1'b0;
    vectors++; if (mcash_ch1_rtn_valid_o !== 1'b1 || ch1_alloc_ready_o !== 1'b1 || ch1_alloc_rob_num_o !== 2'd2) begin
      miscompares++; $display("[TB] FAIL midrst_before: got valid=%b rob=%0d expected 1/2", mcash_ch1_rtn_valid_o, ch1_alloc_rob_num_o); end
    rst_i = 1'b0;
    send_beat(2'd1, 1, DW'(128'h44));
    #1;
    vectors++; if (mcash_ch1_rtn_valid_o !== 1'b0 || ch1_alloc_ready_o !== 1'b1 || ch1_alloc_rob_num_o !== 2'd0) begin
      miscompares++; $display("[TB] FAIL midrst_flush: got valid=%b ready=%b rob=%0d expected 0/1/0", mcash_ch1_rtn_valid_o, ch1_alloc_ready_o, ch1_alloc_rob_num_o); end
    step();
    sc_xbar_valid_i = 1'b0;
    rst_i = 1'b1;
    step();
    ch1_alloc_valid_i = 1'b1;
    #1;
    vectors++; if (mcash_ch1_rtn_valid_o !== 1'b0 || rob_err_o !== 1'b0 || ch1_alloc_rob_num_o !== 2'd0) begin
      miscompares++; $display("[TB] FAIL midrst_after: got valid=%b err=%b rob=%0d expected 0/0/0", mcash_ch1_rtn_valid_o, rob_err_o, ch1_alloc_rob_num_o); end
    step();
    ch1_alloc_valid_i = 1'b0;
  endtask

  task automatic test_wrap();
    mcash_ch0_rtn_ready_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      ch0_alloc_valid_i = (c < 10);
      if (c >= 1 && c <= 10) send_beat(2'd0, (c - 1) % 4, DW'(768 + c - 1));
      else sc_xbar_valid_i = 1'b0;
      #1;
      if (c < 10) begin
        vectors++; if (ch0_alloc_rob_num_o !== AW'(c % 4) || ch0_alloc_ready_o !== 1'b1) begin
          miscompares++; $display("[TB] FAIL wrap_rob_num: got rob=%0d ready=%b expected rob=%0d ready=1", ch0_alloc_rob_num_o, ch0_alloc_ready_o, c % 4); end
      end
      if (c >= 2) begin
        vectors++; if (mcash_ch0_rtn_valid_o !== 1'b1 || mcash_ch0_rtn_data_o !== DW'(768 + c - 2)) begin
          miscompares++; $display("[TB] FAIL wrap_data: got valid=%b data=%h expected valid=1 data=%h", mcash_ch0_rtn_valid_o, mcash_ch0_rtn_data_o, DW'(768 + c - 2)); end
      end else begin
        vectors++; if (mcash_ch0_rtn_valid_o !== 1'b0) begin
          miscompares++; $display("[TB] FAIL wrap_early: got %b expected 0", mcash_ch0_rtn_valid_o); end
      end
      step();
    end
    idle_inputs();
    #1;
    vectors++; if (mcash_ch0_rtn_valid_o !== 1'b0 || rob_err_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL wrap_end: got valid=%b err=%b expected 0/0", mcash_ch0_rtn_valid_o, rob_err_o); end
  endtask

  initial begin
    test_reset();
    test_single_return();
    test_out_of_order();
    test_full_backpressure();
    test_errors();
    test_reset_mid_run();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
